dds_phase_acc: RTL and testbench

DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

---
 rtl/dds_phase_acc_if.sv | 31 +++
 rtl/dds_phase_acc.sv | 133 +++++++++++++
 tb/tb_dds_phase_acc.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_phase_acc_if.sv
// Control and status bundle between the DDS phase accumulator
// and the tuning / phase-locking logic that drives it.
interface dds_phase_acc_if #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10
);
   logic              en;
   logic [ACC_W-1:0]  freq_word;
   logic              freq_valid;
   logic              freq_ready;
   logic [ACC_W-1:0]  phase_offset;
   logic              offset_load;
   logic [ACC_W-1:0]  phase_out;
   logic [ADDR_W-1:0] lut_addr;
   logic              sync;
   logic              settled;

   modport master (
      output en, freq_word, freq_valid,
      output phase_offset, offset_load,
      input  freq_ready, phase_out, lut_addr,
      input  sync, settled
   );

   modport slave (
      input  en, freq_word, freq_valid,
      input  phase_offset, offset_load,
      output freq_ready, phase_out, lut_addr,
      output sync, settled
   );
endinterface

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with phase-continuous retuning and a
// rate-limited phase-offset slewer feeding the sine LUT address.
module dds_phase_acc #(
   parameter int               ACC_W    = 32,
   parameter int               ADDR_W   = 10,
   parameter logic [ACC_W-1:0] DEF_FREQ = ACC_W'(1342177),
   parameter logic [ACC_W-1:0] MAX_STEP = ACC_W'(32'h0010_0000)
) (
   input logic            clk,
   input logic            rst_n,
   dds_phase_acc_if.slave io_bus
);
   typedef enum logic {S_IDLE, S_SLEW} state_t;

   localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_freq_cur;
   logic [ACC_W-1:0] r_pend;
   logic             r_pend_valid;
   logic             r_wrap;
   logic [ACC_W-1:0] r_phase;
   logic             r_sync;
   logic [ACC_W-1:0] r_target;
   logic [ACC_W-1:0] r_off_app;

   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic             w_apply;
   logic             w_accept;
   logic [ACC_W-1:0] w_diff;
   logic [ACC_W-1:0] w_mag;
   logic             w_neg;
   logic             w_close;
   logic [ACC_W-1:0] w_off_nxt;

   assign w_sum    = {1'b0, r_acc} + {1'b0, r_freq_cur};
   assign w_carry  = w_sum[ACC_W];
   assign w_apply  = io_bus.en && w_carry && r_pend_valid;
   assign w_accept = io_bus.freq_valid && !r_pend_valid;

   // A pending word only swaps in on a wrap, keeping phase continuous
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_wrap       <= 1'b0;
         r_freq_cur   <= DEF_FREQ;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_phase      <= '0;
         r_sync       <= 1'b0;
      end else begin
         if (io_bus.en) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_wrap <= w_carry;
         end else begin
            r_wrap <= 1'b0;
         end
         if (w_apply) begin
            r_freq_cur   <= r_pend;
            r_pend_valid <= 1'b0;
         end else if (w_accept) begin
            r_pend       <= io_bus.freq_word;
            r_pend_valid <= 1'b1;
         end
         r_phase <= r_acc + r_off_app;
         r_sync  <= r_wrap;
      end
   end

   // Half-circle distance counts as positive so the slew is deterministic
   assign w_diff  = r_target - r_off_app;
   assign w_neg   = w_diff[ACC_W-1] && (w_diff != MIN_NEG);
   assign w_mag   = w_neg ? ('0 - w_diff) : w_diff;
   assign w_close = (w_mag <= MAX_STEP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (io_bus.offset_load &&
                io_bus.phase_offset != r_off_app)
               w_state_nxt = S_SLEW;
         end
         S_SLEW: begin
            if (!io_bus.offset_load && w_close)
               w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_off_nxt = r_off_app;
      if (r_state == S_SLEW && !io_bus.offset_load) begin
         if (w_close)
            w_off_nxt = r_target;
         else if (w_neg)
            w_off_nxt = r_off_app - MAX_STEP;
         else
            w_off_nxt = r_off_app + MAX_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_target  <= '0;
         r_off_app <= '0;
      end else begin
         if (io_bus.offset_load)
            r_target <= io_bus.phase_offset;
         r_off_app <= w_off_nxt;
      end
   end

   always_comb begin
      io_bus.settled = (r_state == S_IDLE);
   end

   assign io_bus.freq_ready = !r_pend_valid;
   assign io_bus.phase_out  = r_phase;
   assign io_bus.lut_addr   = r_phase[ACC_W-1 -: ADDR_W];
   assign io_bus.sync       = r_sync;
endmodule

// File: tb/tb_dds_phase_acc.sv
// Randomized bench for dds_phase_acc against an arithmetic
// reference model of the accumulator, retune and offset slew.
module tb_dds_phase_acc;
   localparam longint MOD  = 64'h1_0000_0000;
   localparam longint HALF = 64'h8000_0000;
   localparam longint STEP = 64'h0010_0000;
   localparam longint DEFF = 1342177;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dds_phase_acc_if #(.ACC_W(32), .ADDR_W(10)) bus ();

   dds_phase_acc dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_bus(bus)
   );

   int total = 0;
   int bad   = 0;

   longint m_acc, m_freq, m_pend, m_tgt, m_off, m_po;
   bit     m_pv, m_wrap, m_sync, m_slew, g_took;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_freq = DEFF; m_pend = 0; m_pv = 0;
      m_tgt = 0; m_off = 0; m_po = 0;
      m_wrap = 0; m_sync = 0; m_slew = 0;
   endtask

   task automatic model_edge();
      longint s, d;
      bit rdy;
      rdy    = !m_pv;
      g_took = 0;
      m_po   = (m_acc + m_off) % MOD;
      m_sync = m_wrap;
      if (!rst_n) begin
         model_reset();
      end else begin
         s = m_acc + m_freq;
         if (bus.en) begin
            m_wrap = (s >= MOD);
            m_acc  = s % MOD;
         end else begin
            m_wrap = 0;
         end
         if (bus.en && s >= MOD && m_pv) begin
            m_freq = m_pend;
            m_pv   = 0;
         end else if (bus.freq_valid && rdy) begin
            m_pend = longint'(bus.freq_word);
            m_pv   = 1;
            g_took = 1;
         end
         if (bus.offset_load) begin
            m_tgt = longint'(bus.phase_offset);
            if (!m_slew) m_slew = (m_tgt != m_off);
         end else if (m_slew) begin
            d = (m_tgt - m_off + MOD) % MOD;
            if (d > HALF) d = d - MOD;
            if (d <= STEP && d >= -STEP) begin
               m_off  = m_tgt;
               m_slew = 0;
            end else begin
               m_off = (m_off + (d > 0 ? STEP : -STEP) + MOD) % MOD;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("phase_out", bus.phase_out, m_po);
      chk("sync", bus.sync, m_sync);
      chk("settled", bus.settled, !m_slew);
      chk("freq_ready", bus.freq_ready, !m_pv);
      chk("lut_addr", bus.lut_addr, m_po >> 22);
      if (g_took) bus.freq_valid = 1'b0;
      bus.offset_load = 1'b0;
   endtask

   task automatic load(longint v);
      bus.phase_offset = v[31:0];
      bus.offset_load  = 1'b1;
      tick();
   endtask

   task automatic slew_len(string tag, longint v, int want);
      int n;
      n = 0;
      load(v);
      while (!bus.settled && n < 5000) begin
         tick();
         n++;
      end
      chk(tag, n, want);
   endtask

   initial begin
      int first, prev, per;
      longint r;
      model_reset();
      bus.en = 1'b0; bus.freq_word = '0; bus.freq_valid = 1'b0;
      bus.phase_offset = '0; bus.offset_load = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_phase", bus.phase_out, 0);
      chk("rst_sync", bus.sync, 0);
      chk("rst_settled", bus.settled, 1);
      chk("rst_ready", bus.freq_ready, 1);

      rst_n = 1'b1;
      bus.en = 1'b1;
      first = 0; prev = 0; per = 0;
      for (int i = 1; i <= 6500 && per == 0; i++) begin
         tick();
         if (i == 2) chk("phase_e2", bus.phase_out, DEFF);
         if (bus.sync) begin
            if (first == 0) first = i;
            else if (prev == first) per = i - first;
            prev = i;
         end
      end
      chk("first_sync", first, 3202);
      chk("period_ok", (per == 3200 || per == 3201), 1);

      repeat (1000) tick();
      bus.freq_word  = 32'd2684354;
      bus.freq_valid = 1'b1;
      tick();
      chk("ready_low", bus.freq_ready, 0);
      bus.freq_word  = 32'd4000000;
      bus.freq_valid = 1'b1;
      for (int i = 0; i < 4000 && !bus.sync; i++) tick();
      chk("retune_wrap", bus.sync, 1);
      repeat (3) tick();
      chk("second_taken", bus.freq_valid, 0);

      slew_len("slew_4", 64'h0040_0000, 4);
      slew_len("slew_back", 64'h0, 4);
      slew_len("slew_neg", 64'hFFF0_0000, 1);
      slew_len("slew_zero", 64'h0, 1);
      slew_len("slew_half", 64'h8000_0000, 2048);
      slew_len("slew_eq", 64'h8000_0000, 0);

      load(64'h4000_0000);
      repeat (10) tick();
      load(64'h8100_0000);
      chk("retarget_busy", bus.settled, 0);
      repeat (5) tick();
      bus.freq_word  = 32'h0123_4567;
      bus.freq_valid = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_phase", bus.phase_out, 0);
      chk("mid_rst_settled", bus.settled, 1);
      chk("mid_rst_ready", bus.freq_ready, 1);
      chk("mid_rst_sync", bus.sync, 0);
      rst_n = 1'b1;
      bus.freq_valid = 1'b0;

      for (int i = 0; i < 20000; i++) begin
         bus.en = ($urandom_range(7) != 0);
         if (!bus.freq_valid && $urandom_range(40) == 0) begin
            bus.freq_word  = ($urandom_range(3) == 0) ?
                             32'($urandom_range(2000000, 50)) : $urandom;
            bus.freq_valid = 1'b1;
         end
         if ($urandom_range(60) == 0) begin
            case ($urandom_range(3))
               0: r = longint'($urandom);
               1: r = (m_off + $urandom_range(600000)) % MOD;
               2: r = m_off;
               default: r = (m_off + HALF) % MOD;
            endcase
            bus.phase_offset = r[31:0];
            bus.offset_load  = 1'b1;
         end
         rst_n = ($urandom_range(3000) != 0);
         tick();
      end
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
